// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serializes each word as
// start bit, DATA_WIDTH data bits LSB first, stop bit on a registered line.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAP,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q, tx_d;
  logic                    clk_wrap;

  assign clk_wrap = (clk_cnt_q == CNT_LAST);

  // Next-state: the word is captured in CAP, one cycle after the REQ pulse,
  // because the FIFO presents data_out the cycle after rd_en.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = CAP;
      end
      CAP: begin
        shift_d   = fifo_data;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (clk_wrap) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_wrap) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (clk_wrap) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line level is decided from the upcoming state so that the
    // registered tx changes on the same edge as the state does.
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign fifo_rd_en = (state_q == REQ);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && clk_wrap;
  assign tx         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a default instance (16 bits, 4 clocks/bit) and a
// fast instance (8 bits, 1 clock/bit), each fed by a small FIFO model.
module tb_fifo_uart_tx;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        empty0, empty1;
  logic [15:0] fdata0;
  logic [7:0]  fdata1;
  logic        rd0, tx0, busy0, done0;
  logic        rd1, tx1, busy1, done1;

  fifo_uart_tx #(.DATA_WIDTH(16), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(empty0),
    .fifo_data(fdata0), .fifo_rd_en(rd0), .tx(tx0), .busy(busy0),
    .frame_done(done0)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(empty1),
    .fifo_data(fdata1), .fifo_rd_en(rd1), .tx(tx1), .busy(busy1),
    .frame_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models: data_out is valid the cycle after rd_en.
  logic [15:0] mem [2][16];
  int          wr_cnt [2];
  int          rd_ptr [2];

  assign empty0 = (rd_ptr[0] >= wr_cnt[0]);
  assign empty1 = (rd_ptr[1] >= wr_cnt[1]);

  initial begin
    rd_ptr[0] = 0;
    rd_ptr[1] = 0;
    wr_cnt[0] = 0;
    wr_cnt[1] = 0;
    fdata0    = '0;
    fdata1    = '0;
  end

  always @(posedge clk) begin
    if (rd0) begin
      fdata0    <= mem[0][rd_ptr[0] % 16];
      rd_ptr[0] <= rd_ptr[0] + 1;
    end
    if (rd1) begin
      fdata1    <= mem[1][rd_ptr[1] % 16][7:0];
      rd_ptr[1] <= rd_ptr[1] + 1;
    end
  end

  // Behavioural model: position inside the current frame, -1 when idle.
  int          m_pos [2];
  logic [15:0] m_word [2];

  initial begin
    m_pos[0]  = -1;
    m_pos[1]  = -1;
    m_word[0] = '0;
    m_word[1] = '0;
  end

  function automatic int cpb_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int dw_of(input int i);
    return (i == 0) ? 16 : 8;
  endfunction

  function automatic int flen(input int i);
    return 2 + (dw_of(i) + 2) * cpb_of(i);
  endfunction

  // Outputs {rd_en, tx, busy, frame_done} for a given frame position.
  function automatic logic [3:0] expect_out(input int i, input int pos,
                                            input logic [15:0] w);
    logic r, t, b, d;
    int   bit_idx;
    r = 1'b0; t = 1'b1; b = 1'b0; d = 1'b0;
    if (pos >= 0) begin
      b = 1'b1;
      r = (pos == 0);
      d = (pos == flen(i) - 1);
      if (pos >= 2) begin
        bit_idx = (pos - 2) / cpb_of(i);
        if (bit_idx == 0) t = 1'b0;
        else if (bit_idx <= dw_of(i)) t = w[bit_idx - 1];
      end
    end
    return {r, t, b, d};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pos[i] = -1;
      end else if (m_pos[i] >= 0) begin
        m_pos[i] = m_pos[i] + 1;
        if (m_pos[i] == flen(i)) m_pos[i] = -1;
      end else if (enable && !((i == 0) ? empty0 : empty1)) begin
        m_pos[i]  = 0;
        m_word[i] = mem[i][rd_ptr[i] % 16];
      end
    end
  end

  // Scoreboard counters, event logs indexed by negedge number.
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  logic chk_en  = 1'b0;
  logic tx_log0[$], tx_log1[$];
  int   rd_log0[$], rd_log1[$];
  int   done_log0[$], done_log1[$];
  logic [3:0] exp_v, act_v;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        exp_v = expect_out(i, m_pos[i], m_word[i]);
        act_v = (i == 0) ? {rd0, tx0, busy0, done0} : {rd1, tx1, busy1, done1};
        n_total++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL cycle_model dut%0d cyc=%0d {rd,tx,busy,done} got=%b want=%b",
                      i, cyc, act_v, exp_v);
      end
    end
    tx_log0.push_back(tx0);
    tx_log1.push_back(tx1);
    if (rd0) rd_log0.push_back(cyc);
    if (rd1) rd_log1.push_back(cyc);
    if (done0) done_log0.push_back(cyc);
    if (done1) done_log1.push_back(cyc);
    cyc++;
  end

  function automatic logic get_tx(input int i, input int idx);
    if (i == 0) begin
      if (idx >= 0 && idx < tx_log0.size()) return tx_log0[idx];
    end else begin
      if (idx >= 0 && idx < tx_log1.size()) return tx_log1[idx];
    end
    return 1'bx;
  endfunction

  function automatic int rd_cnt(input int i);
    return (i == 0) ? rd_log0.size() : rd_log1.size();
  endfunction

  function automatic int done_cnt(input int i);
    return (i == 0) ? done_log0.size() : done_log1.size();
  endfunction

  function automatic int rd_at(input int i, input int k);
    if (k >= rd_cnt(i)) return -100000;
    return (i == 0) ? rd_log0[k] : rd_log1[k];
  endfunction

  function automatic int done_at(input int i, input int k);
    if (k >= done_cnt(i)) return -100000;
    return (i == 0) ? done_log0[k] : done_log1[k];
  endfunction

  // Decode a frame from the line by sampling mid-bit after the start bit.
  function automatic logic [15:0] decode(input int i, input int rdc);
    logic [15:0] v;
    v = '0;
    for (int b = 0; b < dw_of(i); b++)
      v[b] = get_tx(i, rdc + 2 + cpb_of(i) * (1 + b) + cpb_of(i) / 2);
    return v;
  endfunction

  // Default-instance line levels, start to stop, first bit in the MSB.
  function automatic logic [17:0] levels0(input int rdc, input int off);
    logic [17:0] v;
    for (int b = 0; b < 18; b++) v[17 - b] = get_tx(0, rdc + 2 + 4 * b + off);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", name, act, want);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int i, input logic [15:0] w);
    mem[i][wr_cnt[i] % 16] = w;
    wr_cnt[i] = wr_cnt[i] + 1;
  endtask

  task automatic wait_rd(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (rd_cnt(i) < n && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_rd", 32'(rd_cnt(i) >= n), 32'd1);
  endtask

  task automatic wait_done(input int i, input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt(i) < n && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_done", 32'(done_cnt(i) >= n), 32'd1);
  endtask

  int          rel_idx;
  int          rst_idx;
  int          n_before;
  int          zeros;
  logic [9:0]  seq10;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    push(0, 16'hA5C3);
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset held 3 cycles with a non-empty FIFO and enable high.
    tick(3);
    check("reset_tx", 32'(tx0), 32'd1);
    check("reset_rd_en", 32'(rd0), 32'd0);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_no_rd_during", 32'(rd_cnt(0)), 32'd0);
    rel_idx = cyc - 1;
    rst_n = 1'b1;

    // Single word A5C3: REQ follows the first edge that samples rst_n high.
    wait_rd(0, 1, 10);
    check("first_rd_offset", 32'(rd_at(0, 0) - rel_idx), 32'd1);
    wait_done(0, 1, 100);
    tick(5);
    check("single_rd_count", 32'(rd_cnt(0)), 32'd1);
    check("single_done_count", 32'(done_cnt(0)), 32'd1);
    check("single_done_offset", 32'(done_at(0, 0) - rd_at(0, 0)), 32'd73);
    check("single_levels_first", 32'(levels0(rd_at(0, 0), 0)),
          32'(18'b0_1100001110100101_1));
    check("single_levels_last", 32'(levels0(rd_at(0, 0), 3)),
          32'(18'b0_1100001110100101_1));

    // Back-to-back pair.
    push(0, 16'h0001);
    push(0, 16'h8000);
    wait_done(0, 3, 300);
    tick(100);
    check("b2b_rd_count", 32'(rd_cnt(0)), 32'd3);
    check("b2b_period", 32'(rd_at(0, 2) - rd_at(0, 1)), 32'd75);
    check("b2b_word0", 32'(decode(0, rd_at(0, 1))), 32'h0001);
    check("b2b_word1", 32'(decode(0, rd_at(0, 2))), 32'h8000);

    // Empty FIFO for 100 cycles.
    n_before = rd_cnt(0);
    zeros = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (tx0 !== 1'b1) zeros++;
    end
    check("empty_no_rd", 32'(rd_cnt(0)), 32'(n_before));
    check("empty_line_idle", 32'(zeros), 32'd0);

    // enable dropped 10 cycles into a frame.
    push(0, 16'h1234);
    push(0, 16'h5678);
    wait_rd(0, 4, 10);
    tick(10);
    enable = 1'b0;
    wait_done(0, 4, 150);
    tick(100);
    check("dis_rd_count", 32'(rd_cnt(0)), 32'd4);
    check("dis_word", 32'(decode(0, rd_at(0, 3))), 32'h1234);
    check("dis_fifo_left", 32'(wr_cnt[0] - rd_ptr[0]), 32'd1);

    // Reset during data bit 5 of the 5678 frame.
    push(0, 16'h9ABC);
    enable = 1'b1;
    wait_rd(0, 5, 10);
    tick(rd_at(0, 4) + 27 - (cyc - 1));
    check("rst_mid_in_frame", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check("rst_mid_tx", 32'(tx0), 32'd1);
    check("rst_mid_busy", 32'(busy0), 32'd0);
    check("rst_mid_rd_en", 32'(rd0), 32'd0);
    rst_idx = cyc - 1;
    rst_n = 1'b1;
    wait_rd(0, 6, 10);
    check("rst_restart_offset", 32'(rd_at(0, 5) - rst_idx), 32'd1);
    wait_done(0, 5, 150);
    tick(20);
    check("rst_next_word", 32'(decode(0, rd_at(0, 5))), 32'h9ABC);
    check("rst_rd_count", 32'(rd_cnt(0)), 32'd6);
    check("rst_done_count", 32'(done_cnt(0)), 32'd5);

    // One clock per bit, 8-bit word 5A.
    push(1, 16'h005A);
    wait_done(1, 1, 50);
    tick(5);
    for (int k = 0; k < 10; k++) seq10[9 - k] = get_tx(1, rd_at(1, 0) + 2 + k);
    check("fast_levels", 32'(seq10), 32'(10'b0010110101));
    check("fast_done_offset", 32'(done_at(1, 0) - rd_at(1, 0)), 32'd11);
    check("fast_rd_count", 32'(rd_cnt(1)), 32'd1);

    push(1, 16'h00C3);
    push(1, 16'h0081);
    wait_done(1, 3, 80);
    tick(5);
    check("fast_b2b_period", 32'(rd_at(1, 2) - rd_at(1, 1)), 32'd13);
    check("fast_word0", 32'(decode(1, rd_at(1, 1))), 32'h00C3);
    check("fast_word1", 32'(decode(1, rd_at(1, 2))), 32'h0081);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
